// File: rtl/uff_pkg.sv
// Shared definitions for the universal flip-flop bank: operating mode encoding.
package uff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_D  = 2'b00;
    localparam mode_t MODE_T  = 2'b01;
    localparam mode_t MODE_JK = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/uff_cell.sv
// One flip-flop channel's next-state function for D/T/JK/SR modes, plus
// detection of the illegal SR input (S=R=1). Purely combinational.
module uff_cell
    import uff_pkg::*;
(
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  nxt,
    output logic  illegal
);

    // Next state of this channel assuming the bank is enabled
    always_comb begin
        nxt = q;
        case (mode)
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_SR: begin
                case ({a, b})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
    end

    // S=R=1 in SR mode holds the bit but is flagged to the bank
    always_comb begin
        illegal = (mode == MODE_SR) && a && b;
    end

endmodule

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH flip-flops sharing one mode, with parallel load, per-bit
// change flags, sticky illegal-SR flags and a saturating change counter.
module universal_ff_bank
    import uff_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    logic [WIDTH-1:0] cell_nxt;
    logic [WIDTH-1:0] cell_illegal;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] set_err;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        uff_cell u_cell (
            .mode    (mode),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .nxt     (cell_nxt[i]),
            .illegal (cell_illegal[i])
        );
    end

    // Load beats enable; with neither asserted the bank holds
    always_comb begin
        if (load) begin
            next_q = load_val;
        end else if (en) begin
            next_q = cell_nxt;
        end else begin
            next_q = q;
        end
        set_err = (en && !load) ? cell_illegal : '0;
    end

    // Register state, change flags, sticky errors and the saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            changed <= '0;
            sr_err  <= '0;
            chg_cnt <= '0;
        end else begin
            q       <= next_q;
            changed <= next_q ^ q;
            // A fresh illegal condition wins over err_clr on the same edge
            sr_err  <= (err_clr ? '0 : sr_err) | set_err;
            if ((next_q != q) && (chg_cnt != '1)) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end
    end

    // Complement output straight from the register
    always_comb begin
        q_n = ~q;
    end

endmodule

// File: tb/tb_universal_ff_bank.sv
// Self-checking bench for universal_ff_bank (WIDTH=4, RESET_VAL=0, CNT_W=3).
module tb_universal_ff_bank;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  q, q_n, changed, sr_err;
    logic [CW-1:0] chg_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] mq, mch, merr;
    int           mcnt;

    universal_ff_bank #(
        .WIDTH     (W),
        .RESET_VAL (4'b0000),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .load     (load),
        .load_val (load_val),
        .err_clr  (err_clr),
        .q        (q),
        .q_n      (q_n),
        .changed  (changed),
        .sr_err   (sr_err),
        .chg_cnt  (chg_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model from characteristic equations, applied once per edge
    task automatic step();
        logic [W-1:0] nq;
        @(posedge clk);
        if (reset) begin
            mq = '0; mch = '0; merr = '0; mcnt = 0;
        end else begin
            if (load)          nq = load_val;
            else if (!en)      nq = mq;
            else if (mode == 0) nq = a;
            else if (mode == 1) nq = mq ^ a;
            else if (mode == 2) nq = (a & ~mq) | (~b & mq);
            else               nq = (a & ~b) | (mq & ~(a ^ b));
            mch = nq ^ mq;
            if (nq != mq && mcnt < 7) mcnt = mcnt + 1;
            merr = (err_clr ? 4'b0000 : merr) | ((mode == 3 && en && !load) ? (a & b) : 4'b0000);
            mq = nq;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; en = 0; load = 0; err_clr = 0; a = '0; b = '0; load_val = '0;
    endtask

    task automatic test_reset();
        reset = 1; load = 1; load_val = 4'b1111; en = 1; mode = 2'b00; a = 4'b1111; err_clr = 1;
        step();
        tests++; if (q !== 4'b0000) begin fails++; $display("FAIL reset_q got %b want 0000", q); end
        tests++; if (q_n !== 4'b1111) begin fails++; $display("FAIL reset_qn got %b want 1111", q_n); end
        tests++; if (changed !== 4'b0000 || sr_err !== 4'b0000) begin fails++; $display("FAIL reset_flags got ch=%b err=%b want 0000/0000", changed, sr_err); end
        tests++; if (chg_cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", chg_cnt); end
        idle_inputs();
    endtask

    task automatic test_toggle();
        mode = 2'b01; en = 1; a = 4'b1111;
        step();
        tests++; if (q !== 4'b1111 || changed !== 4'b1111) begin fails++; $display("FAIL t_edge1 got q=%b ch=%b want 1111/1111", q, changed); end
        step();
        tests++; if (q !== 4'b0000 || changed !== 4'b1111) begin fails++; $display("FAIL t_edge2 got q=%b ch=%b want 0000/1111", q, changed); end
        tests++; if (chg_cnt !== 3'd2) begin fails++; $display("FAIL t_cnt got %0d want 2", chg_cnt); end
        idle_inputs();
    endtask

    task automatic test_jk();
        mode = 2'b10; en = 1; a = 4'b1100; b = 4'b1010;
        step();
        // bit3 J=K=1 toggles, bit2 sets, bit1 clears, bit0 holds
        tests++; if (q !== 4'b1100 || changed !== 4'b1100) begin fails++; $display("FAIL jk_edge1 got q=%b ch=%b want 1100/1100", q, changed); end
        step();
        tests++; if (q !== 4'b0100 || changed !== 4'b1000) begin fails++; $display("FAIL jk_edge2 got q=%b ch=%b want 0100/1000", q, changed); end
        idle_inputs();
    endtask

    task automatic test_sr();
        mode = 2'b11; en = 1; a = 4'b0011; b = 4'b0101;
        step();
        tests++; if (q !== 4'b0010 || sr_err !== 4'b0001) begin fails++; $display("FAIL sr_edge got q=%b err=%b want 0010/0001", q, sr_err); end
        err_clr = 1;
        step();
        tests++; if (sr_err !== 4'b0001) begin fails++; $display("FAIL sr_clr_same got %b want 0001", sr_err); end
        a = 4'b0000; b = 4'b0000;
        step();
        tests++; if (sr_err !== 4'b0000) begin fails++; $display("FAIL sr_clr got %b want 0000", sr_err); end
        tests++; if (q !== 4'b0010 || changed !== 4'b0000) begin fails++; $display("FAIL sr_hold got q=%b ch=%b want 0010/0000", q, changed); end
        idle_inputs();
    endtask

    task automatic test_saturate();
        reset = 1;
        step();
        reset = 0; mode = 2'b00; en = 1;
        for (int i = 0; i < 9; i++) begin
            a = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            step();
        end
        tests++; if (chg_cnt !== 3'd7) begin fails++; $display("FAIL sat_cnt got %0d want 7", chg_cnt); end
        step();
        tests++; if (changed !== 4'b0000 || chg_cnt !== 3'd7) begin fails++; $display("FAIL sat_hold got ch=%b cnt=%0d want 0000/7", changed, chg_cnt); end
        idle_inputs();
    endtask

    task automatic test_load();
        load = 1; load_val = 4'b1010; en = 0;
        step();
        tests++; if (q !== 4'b1010) begin fails++; $display("FAIL load_q got %b want 1010", q); end
        reset = 1;
        step();
        tests++; if (q !== 4'b0000 || changed !== 4'b0000 || sr_err !== 4'b0000 || chg_cnt !== 3'd0)
        begin fails++; $display("FAIL load_reset got q=%b ch=%b err=%b cnt=%0d want all 0", q, changed, sr_err, chg_cnt); end
        idle_inputs();
    endtask

    task automatic test_hold();
        logic [W-1:0] q0, e0;
        // Prime a non-zero state and some sticky errors first
        load = 1; load_val = 4'b0110;
        step();
        load = 0; en = 1; mode = 2'b11; a = 4'b1001; b = 4'b1001;
        step();
        en = 0; q0 = mq; e0 = merr;
        for (int m = 0; m < 4; m++) begin
            mode = m[1:0]; a = 4'($urandom); b = 4'($urandom);
            step();
            tests++; if (q !== q0 || changed !== 4'b0000 || sr_err !== e0)
            begin fails++; $display("FAIL hold_m%0d got q=%b ch=%b err=%b want %b/0000/%b", m, q, changed, sr_err, q0, e0); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            mode     = 2'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            load_val = 4'($urandom);
            step();
            tests++;
            if (q !== mq || q_n !== ~mq || changed !== mch || sr_err !== merr || chg_cnt !== CW'(mcnt)) begin
                fails++;
                $display("FAIL rand_%0d got q=%b qn=%b ch=%b err=%b cnt=%0d want %b/%b/%b/%b/%0d",
                         i, q, q_n, changed, sr_err, chg_cnt, mq, ~mq, mch, merr, mcnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        mq = '0; mch = '0; merr = '0; mcnt = 0;
        test_reset();
        test_toggle();
        test_jk();
        test_sr();
        test_saturate();
        test_load();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
